// File: rtl/i2f_pkg.sv
// i2f_pkg: shared widths, result struct and slot states for the shared int-to-float converter
package i2f_pkg;
  localparam int INT_W = 11;
  localparam int MAN_W = 4;
  localparam int EXP_W = 3;
  localparam int EXP_MAX = 7;
  typedef struct packed {
    logic [MAN_W-1:0] m;
    logic [EXP_W-1:0] e;
  } i2f_res_t;
  typedef enum logic {EMPTY, FULL} slot_t;
endpackage

// File: rtl/i2f_share_arbiter_if.sv
// i2f_share_arbiter_if: requester valid/ready/data bundle plus the tagged float result handshake
interface i2f_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W = N_REQ > 1 ? $clog2(N_REQ) : 1
) ();
  import i2f_pkg::*;
  logic [N_REQ-1:0] in_valid;
  logic [N_REQ-1:0] in_ready;
  logic [N_REQ*INT_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [MAN_W-1:0] out_m;
  logic [EXP_W-1:0] out_e;
  logic [ID_W-1:0] out_id;
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_m, out_e, out_id);
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_m, out_e, out_id);
endinterface

// File: rtl/i2f_convert.sv
// i2f_convert: leading-one detect and 4-bit mantissa select (truncating by default).
// Defining I2F_ROUND_EN rounds half-up on the bit below the mantissa, saturating at E=7.
module i2f_convert
  import i2f_pkg::*;
(
  input  logic [INT_W-1:0] b,
  output i2f_res_t         res
);
  logic [3:0] k;
  logic [EXP_W-1:0] sh;
  logic [MAN_W-1:0] t;
  logic big;
`ifdef I2F_ROUND_EN
  logic rb;
  logic [MAN_W:0] sum;
`endif
  always_comb begin
    k = '0;
    for (int i = 0; i < INT_W; i++) k = b[i] ? 4'(i) : k;
    big = |b[INT_W-1:MAN_W];
    sh = EXP_W'(k - 4'd3);
    t = MAN_W'(b >> sh);
`ifdef I2F_ROUND_EN
    rb = 1'(b >> (sh - EXP_W'(1)));
    sum = {1'b0, t} + {{MAN_W{1'b0}}, rb};
    res.m = !big ? b[MAN_W-1:0] : !sum[MAN_W] ? sum[MAN_W-1:0] : sh == EXP_W'(EXP_MAX) ? '1 : MAN_W'(8);
    res.e = !big ? '0 : (sum[MAN_W] && sh != EXP_W'(EXP_MAX)) ? sh + EXP_W'(1) : sh;
`else
    res.m = big ? t : b[MAN_W-1:0];
    res.e = big ? sh : '0;
`endif
  end
endmodule

// File: rtl/i2f_share_arbiter.sv
// i2f_share_arbiter: round-robin sharing of one int-to-float converter behind a single tagged output slot.
// Build with I2F_ROUND_EN for round-half-up mantissas; handshakes and latency are unchanged.
module i2f_share_arbiter
  import i2f_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
  input logic clk,
  input logic rst_n,
  i2f_share_arbiter_if.slave bus
);
  slot_t state, state_n;
  logic [ID_W-1:0] rr_ptr, g, id_q;
  logic load;
  i2f_res_t conv, res_q;
  always_comb begin
    g = '0;
    for (int j = N_REQ - 1; j >= 0; j--)
      g = bus.in_valid[(int'(rr_ptr) + j) % N_REQ] ? ID_W'((int'(rr_ptr) + j) % N_REQ) : g;
    load = (state == EMPTY || bus.out_ready) && |bus.in_valid;
    state_n = load ? FULL : bus.out_ready ? EMPTY : state;
    bus.in_ready = load ? N_REQ'(1) << g : '0;
  end
  i2f_convert u_conv (.b(bus.in_data[INT_W*g +: INT_W]), .res(conv));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      rr_ptr <= '0;
      res_q <= '0;
      id_q <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        res_q <= conv;
        id_q <= g;
        rr_ptr <= g == ID_W'(N_REQ - 1) ? '0 : g + ID_W'(1);
      end
    end
  assign bus.out_valid = state == FULL;
  assign bus.out_m = res_q.m;
  assign bus.out_e = res_q.e;
  assign bus.out_id = id_q;
endmodule
